// File: rtl/wb_cw_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_cw_arbiter_pkg
// Description : Shared bus widths, master request bundle and counter sizing
//               helper for the two-master compressed-bus arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package wb_cw_arbiter_pkg;

    // Bus widths shared with the compressor.
    localparam int RW        = 16;
    localparam int WB_ADDR_W = 24;

    // Everything a master presents towards the slave, bundled for one-shot muxing.
    typedef struct packed {
        logic                 cyc;
        logic                 stb;
        logic                 we;
        logic [WB_ADDR_W-1:0] adr;
        logic [RW-1:0]        dat;
        logic [1:0]           sel;
        logic                 burst8;
        logic                 burst4;
    } wb_req_t;

    // Counter width able to hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ack_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_ack_watchdog
// Description : Saturating count of consecutive stalled cycles; flags expiry
//               on the WDT_CYCLES-th stalled cycle. WDT_CYCLES = 0 disables.
// Revision    : 1.0  initial release
// ============================================================================
module wb_ack_watchdog
    import wb_cw_arbiter_pkg::*;
#(
    parameter int WDT_CYCLES = 1023
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic stall,
    input  logic clr,
    output logic expire
);

    localparam int CW = cnt_width(WDT_CYCLES);

    generate
        if (WDT_CYCLES == 0) begin : g_wdt_off
            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_rst, stall, clr};
            assign expire   = 1'b0;
        end else begin : g_wdt_on
            localparam logic [CW-1:0] c_last = CW'(WDT_CYCLES - 1);

            logic [CW-1:0] cnt_q;

            // Count stalled cycles; clear has priority, and the count holds at all-ones.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    cnt_q <= '0;
                end else if (clr) begin
                    cnt_q <= '0;
                end else if (stall && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            // Expiry only while the stall is still present in this cycle.
            assign expire = stall && (cnt_q == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_cw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_cw_arbiter
// Description : Round-robin arbiter sharing one Wishbone port between the
//               fetch master (m0) and data master (m1). Grant is held for the
//               whole cyc assertion; a watchdog aborts hung transfers.
// Revision    : 1.0  initial release
// ============================================================================
module wb_cw_arbiter
    import wb_cw_arbiter_pkg::*;
#(
    parameter int WDT_CYCLES = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    // master 0 (instruction fetch)
    input  logic                 m0_cyc,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    input  logic [WB_ADDR_W-1:0] m0_adr,
    input  logic [RW-1:0]        m0_o_dat,
    input  logic [1:0]           m0_sel,
    input  logic                 m0_8_burst,
    input  logic                 m0_4_burst,
    output logic [RW-1:0]        m0_i_dat,
    output logic                 m0_ack,
    output logic                 m0_err,
    // master 1 (data)
    input  logic                 m1_cyc,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    input  logic [WB_ADDR_W-1:0] m1_adr,
    input  logic [RW-1:0]        m1_o_dat,
    input  logic [1:0]           m1_sel,
    input  logic                 m1_8_burst,
    input  logic                 m1_4_burst,
    output logic [RW-1:0]        m1_i_dat,
    output logic                 m1_ack,
    output logic                 m1_err,
    // shared port towards the compressor
    output logic                 s_cyc,
    output logic                 s_stb,
    output logic                 s_we,
    output logic [WB_ADDR_W-1:0] s_adr,
    output logic [RW-1:0]        s_o_dat,
    output logic [1:0]           s_sel,
    output logic                 s_8_burst,
    output logic                 s_4_burst,
    input  logic [RW-1:0]        s_i_dat,
    input  logic                 s_ack,
    input  logic                 s_err,
    // status
    output logic                 o_owner,
    output logic                 o_busy,
    output logic                 o_wdt_trip
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_busy  = 2'd1;
    localparam logic [1:0] c_st_abort = 2'd2;

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q,  last_d;
    logic       err_pls_q, err_pls_d;
    logic       trip_q,  trip_d;

    wb_req_t w_m0, w_m1, w_own, w_bus;
    logic    w_req0, w_req1, w_win;
    logic    w_fwd, w_stall, w_clr, w_expire;

    assign w_m0 = '{cyc: m0_cyc, stb: m0_stb, we: m0_we, adr: m0_adr, dat: m0_o_dat,
                    sel: m0_sel, burst8: m0_8_burst, burst4: m0_4_burst};
    assign w_m1 = '{cyc: m1_cyc, stb: m1_stb, we: m1_we, adr: m1_adr, dat: m1_o_dat,
                    sel: m1_sel, burst8: m1_8_burst, burst4: m1_4_burst};

    assign w_own  = owner_q ? w_m1 : w_m0;
    assign w_req0 = m0_cyc & m0_stb;
    assign w_req1 = m1_cyc & m1_stb;
    // On a tie the master that did not win last time goes next.
    assign w_win  = (w_req0 & w_req1) ? ~last_q : w_req1;

    // Only a live BUSY transfer connects master and slave in either direction.
    assign w_fwd   = (state_q == c_st_busy);
    assign w_stall = w_fwd & w_own.cyc & w_own.stb & ~(s_ack | s_err);
    assign w_clr   = ~w_stall | w_expire;

    wb_ack_watchdog #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .stall  (w_stall),
        .clr    (w_clr),
        .expire (w_expire)
    );

    // Next-state logic: grant from IDLE, release on owner cyc low, abort on expiry.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        err_pls_d = 1'b0;
        trip_d    = trip_q;
        case (state_q)
            c_st_idle: begin
                if (w_req0 | w_req1) begin
                    owner_d = w_win;
                    last_d  = w_win;
                    state_d = c_st_busy;
                end
            end
            c_st_busy: begin
                if (!w_own.cyc) begin
                    state_d = c_st_idle;
                end else if (w_expire) begin
                    state_d   = c_st_abort;
                    err_pls_d = 1'b1;
                    trip_d    = 1'b1;
                end
            end
            c_st_abort: begin
                if (!w_own.cyc) begin
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // State registers; reset leaves m0 favoured on the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= c_st_idle;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            err_pls_q <= 1'b0;
            trip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            err_pls_q <= err_pls_d;
            trip_q    <= trip_d;
        end
    end

    assign w_bus     = w_fwd ? w_own : '0;
    assign s_cyc     = w_bus.cyc;
    assign s_stb     = w_bus.stb;
    assign s_we      = w_bus.we;
    assign s_adr     = w_bus.adr;
    assign s_o_dat   = w_bus.dat;
    assign s_sel     = w_bus.sel;
    assign s_8_burst = w_bus.burst8;
    assign s_4_burst = w_bus.burst4;

    // The watchdog error pulse is generated here, not passed through from the slave.
    assign m0_ack   = w_fwd & ~owner_q & s_ack;
    assign m0_err   = (w_fwd & ~owner_q & s_err) | (err_pls_q & ~owner_q);
    assign m0_i_dat = (w_fwd & ~owner_q) ? s_i_dat : '0;
    assign m1_ack   = w_fwd & owner_q & s_ack;
    assign m1_err   = (w_fwd & owner_q & s_err) | (err_pls_q & owner_q);
    assign m1_i_dat = (w_fwd & owner_q) ? s_i_dat : '0;

    assign o_owner    = owner_q;
    assign o_busy     = (state_q != c_st_idle);
    assign o_wdt_trip = trip_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_cw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_cw_arbiter
// Description : Directed bench for wb_cw_arbiter with a transaction-level
//               reference model compared every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_cw_arbiter;
    import wb_cw_arbiter_pkg::*;

    localparam int WDT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic                 mc[2], ms[2], mw[2], mb8[2], mb4[2];
    logic [WB_ADDR_W-1:0] madr[2];
    logic [RW-1:0]        mdo[2];
    logic [1:0]           msel[2];

    logic [RW-1:0]        m0_i_dat, m1_i_dat;
    logic                 m0_ack, m0_err, m1_ack, m1_err;
    logic                 s_cyc, s_stb, s_we, s_8_burst, s_4_burst;
    logic [WB_ADDR_W-1:0] s_adr;
    logic [RW-1:0]        s_o_dat;
    logic [1:0]           s_sel;
    logic [RW-1:0]        sdi;
    logic                 sack, serr;
    logic                 o_owner, o_busy, o_wdt_trip;

    int n_cmp = 0;
    int n_bad = 0;

    wb_cw_arbiter #(.WDT_CYCLES(WDT)) dut (
        .i_clk(clk), .i_rst(rst),
        .m0_cyc(mc[0]), .m0_stb(ms[0]), .m0_we(mw[0]), .m0_adr(madr[0]), .m0_o_dat(mdo[0]),
        .m0_sel(msel[0]), .m0_8_burst(mb8[0]), .m0_4_burst(mb4[0]),
        .m0_i_dat(m0_i_dat), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(mc[1]), .m1_stb(ms[1]), .m1_we(mw[1]), .m1_adr(madr[1]), .m1_o_dat(mdo[1]),
        .m1_sel(msel[1]), .m1_8_burst(mb8[1]), .m1_4_burst(mb4[1]),
        .m1_i_dat(m1_i_dat), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_o_dat(s_o_dat),
        .s_sel(s_sel), .s_8_burst(s_8_burst), .s_4_burst(s_4_burst),
        .s_i_dat(sdi), .s_ack(sack), .s_err(serr),
        .o_owner(o_owner), .o_busy(o_busy), .o_wdt_trip(o_wdt_trip)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // gr: -1 nobody holds the port, else index of the granted master.
    int m_gr = -1, m_owner = 0, m_last = 1, m_stall = 0;
    bit m_abort = 1'b0, m_errp = 1'b0, m_trip = 1'b0;

    always @(posedge clk or posedge rst) begin
        int w;
        bit r0, r1;
        if (rst) begin
            m_gr <= -1; m_owner <= 0; m_last <= 1; m_stall <= 0;
            m_abort <= 1'b0; m_errp <= 1'b0; m_trip <= 1'b0;
        end else begin
            m_errp <= 1'b0;
            r0 = mc[0] && ms[0];
            r1 = mc[1] && ms[1];
            if (m_gr < 0) begin
                if (r0 || r1) begin
                    w = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
                    m_gr <= w; m_owner <= w; m_last <= w;
                end
                m_stall <= 0;
            end else if (!m_abort) begin
                if (!mc[m_gr]) begin
                    m_gr <= -1; m_stall <= 0;
                end else if (ms[m_gr] && !sack && !serr) begin
                    if (m_stall + 1 == WDT) begin
                        m_abort <= 1'b1; m_errp <= 1'b1; m_trip <= 1'b1; m_stall <= 0;
                    end else begin
                        m_stall <= m_stall + 1;
                    end
                end else begin
                    m_stall <= 0;
                end
            end else if (!mc[m_owner]) begin
                m_gr <= -1; m_abort <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [46:0] es;
        logic [17:0] e0, e1;
        bit act;
        int g;
        act = (m_gr >= 0) && !m_abort;
        g   = (m_gr < 0) ? 0 : m_gr;
        es  = act ? {mc[g], ms[g], mw[g], madr[g], mdo[g], msel[g], mb8[g], mb4[g]} : '0;
        e0  = '0;
        e1  = '0;
        if (act) begin
            if (g == 0) e0 = {sack, serr, sdi};
            else        e1 = {sack, serr, sdi};
        end
        if (m_abort && m_errp) begin
            if (m_owner == 0) e0[16] = 1'b1;
            else              e1[16] = 1'b1;
        end
        check("s_bus", {s_cyc, s_stb, s_we, s_adr, s_o_dat, s_sel, s_8_burst, s_4_burst}, es);
        check("m0_resp", {m0_ack, m0_err, m0_i_dat}, e0);
        check("m1_resp", {m1_ack, m1_err, m1_i_dat}, e1);
        check("status", {o_busy, o_wdt_trip}, {(m_gr >= 0), m_trip});
        if (m_gr >= 0) check("owner", o_owner, m_owner[0]);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic cyc, input logic stb, input logic [23:0] adr);
        mc[i] = cyc; ms[i] = stb; madr[i] = adr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; ms[i] = 0; mw[i] = 0; mb8[i] = 0; mb4[i] = 0;
            madr[i] = '0; mdo[i] = '0; msel[i] = 2'b11;
        end
        sack = 0; serr = 0; sdi = '0;
        do_reset();
        check("rst_idle", {s_cyc, s_stb, o_busy, o_owner, o_wdt_trip}, 5'b0);

        // Single m0 read
        req(0, 1, 1, 24'h004000);
        tick();
        check("t1_grant", {s_cyc, s_adr}, {1'b1, 24'h004000});
        sack = 1; sdi = 16'hBEEF;
        #1;
        check("t1_ack", {m0_ack, m0_i_dat, m1_ack}, {1'b1, 16'hBEEF, 1'b0});
        tick();
        sack = 0; sdi = '0; req(0, 0, 0, '0);
        tick();
        tick();

        // Tie from reset, then alternation with a one-cycle gap
        do_reset();
        req(0, 1, 1, 24'h000100);
        req(1, 1, 1, 24'h000200);
        tick();
        check("t2_tie", {o_owner, s_adr}, {1'b0, 24'h000100});
        sack = 1;
        tick();
        sack = 0; req(0, 0, 0, 24'h000100);
        tick();
        check("t2_gap", s_cyc, 1'b0);
        req(0, 1, 1, 24'h000100);
        tick();
        check("t2_alt", {o_owner, s_cyc, s_adr}, {1'b1, 1'b1, 24'h000200});
        sack = 1;
        tick();
        sack = 0; req(1, 0, 0, '0);
        tick();
        tick();
        check("t2_back", o_owner, 1'b0);
        sack = 1;
        tick();
        sack = 0; req(0, 0, 0, '0);
        tick();
        tick();

        // 8-beat write burst on m1 with 3-cycle stb gaps while m0 waits
        mw[1] = 1; mb8[1] = 1; mdo[1] = 16'h1000;
        req(1, 1, 1, 24'h000300);
        tick();
        req(0, 1, 1, 24'h000400);
        for (int b = 0; b < 8; b++) begin
            ms[1] = 1; mdo[1] = 16'h1000 + 16'(b); sack = 1;
            #1;
            check("t3_beat", {o_owner, m1_ack, m0_ack}, 3'b110);
            tick();
            sack = 0; ms[1] = 0;
            if (b < 7) begin
                repeat (3) tick();
            end
        end
        mc[1] = 0; mw[1] = 0; mb8[1] = 0;
        tick();
        check("t3_rel", {s_cyc, o_busy}, 2'b00);
        tick();
        check("t3_m0", {o_owner, s_cyc, s_adr}, {1'b0, 1'b1, 24'h000400});
        sack = 1;
        tick();
        sack = 0; req(0, 0, 0, '0);
        tick();
        tick();

        // Watchdog trip after 4 stalled cycles
        req(0, 1, 1, 24'h000500);
        tick();
        for (int k = 1; k <= 4; k++) begin
            check("t4_noerr", {m0_err, o_wdt_trip}, 2'b00);
            tick();
        end
        check("t4_err", {m0_err, o_wdt_trip, s_cyc, s_stb}, 4'b1100);
        tick();
        check("t4_pulse1", {m0_err, o_wdt_trip, s_cyc}, 3'b010);
        sack = 1;
        #1;
        check("t4_late", {m0_ack, m0_err}, 2'b00);
        tick();
        sack = 0; req(0, 0, 0, '0);
        tick();
        check("t4_sticky", {o_busy, o_wdt_trip}, 2'b01);

        // Ack in the same cycle the watchdog would expire
        do_reset();
        req(0, 1, 1, 24'h000500);
        tick();
        tick();
        tick();
        tick();
        sack = 1;
        #1;
        check("t5_ack", {m0_ack, m0_err}, 2'b10);
        tick();
        sack = 0;
        check("t5_notrip", {m0_err, o_wdt_trip, o_busy}, 3'b001);
        req(0, 0, 0, '0);
        tick();
        tick();

        // Asynchronous reset during beat 3 of a 4-beat read
        mb4[0] = 1;
        req(0, 1, 1, 24'h000600);
        tick();
        req(1, 1, 1, 24'h000700);
        sack = 1; sdi = 16'h0001;
        tick();
        sdi = 16'h0002;
        tick();
        sdi = 16'h0003;
        rst = 1;
        #1;
        check("t6_rst", {s_cyc, s_stb, s_adr, m0_ack, m0_i_dat, o_busy}, '0);
        sack = 0; sdi = '0; mb4[0] = 0; req(0, 0, 0, '0);
        tick();
        rst = 0;
        tick();
        check("t6_m1", {o_owner, s_cyc, s_adr}, {1'b1, 1'b1, 24'h000700});
        sack = 1;
        tick();
        sack = 0; req(1, 0, 0, '0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
